// File: rtl/keyentry_pkg.sv
// Shared definitions for the key entry accumulator: FSM state encoding,
// key code classes and the digit classification helper.
package keyentry_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS_DB,
    ST_COMMIT,
    ST_HOLD,
    ST_RELEASE_DB
  } key_state_e;

  localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;
  localparam logic [3:0] KEY_BACKSPACE = 4'hF;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= KEY_DIGIT_MAX;
  endfunction

endpackage

// File: rtl/key_stable_counter.sv
// Stability counter for debounce: counts enabled cycles since the last clear and
// flags when CYCLES-1 is reached. Saturates there so it can never wrap.
module key_stable_counter #(
  parameter int unsigned CYCLES = 16
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int unsigned CW = $clog2(CYCLES);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign done = (count == LAST);

endmodule

// File: rtl/key_entry_accumulator.sv
// Debounces keyboardCtrl key events, shifts digits into a BCD operand and hands
// function keys to the calculator over valid/ready. Optional macro: KEYENTRY_BACKSPACE_EN.
module key_entry_accumulator
  import keyentry_pkg::*;
#(
  parameter  int unsigned NDIGITS         = 8,
  parameter  int unsigned DEBOUNCE_CYCLES = 16,
  localparam int unsigned CNT_W           = $clog2(NDIGITS + 1)
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   KeyRead,
  input  logic [0:3]             BCDKey,
  input  logic                   ClearEntry,
  input  logic                   FuncReady,
  output logic [4*NDIGITS-1:0]   Operand,
  output logic [CNT_W-1:0]       DigitCount,
  output logic                   EntryOverflow,
  output logic                   FuncValid,
  output logic [3:0]             FuncCode,
  output logic                   KeyEvent
);

  localparam logic [CNT_W-1:0] MAX_DIGITS = CNT_W'(NDIGITS);

  key_state_e state, state_nxt;
  logic [3:0] raw_code;
  logic [3:0] key_code;
  logic       latch_code;
  logic       cnt_clear;
  logic       cnt_enable;
  logic       cnt_done;
  logic       commit;
  logic       is_bksp;
  logic       is_func;
  logic       commit_digit;
  logic       commit_func;
  logic       commit_bksp;

  // BCDKey is declared [0:3] with bit 0 as MSB, so a plain assignment keeps the numeric value.
  assign raw_code = BCDKey;

`ifdef KEYENTRY_BACKSPACE_EN
  assign is_bksp = (key_code == KEY_BACKSPACE);
`else
  assign is_bksp = 1'b0;
`endif
  assign is_func = !is_digit(key_code) && !is_bksp;

  key_stable_counter #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_stable_counter (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .done    (cnt_done)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output of this block is given a default first, so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    latch_code = 1'b0;
    cnt_clear  = 1'b1;
    cnt_enable = 1'b0;
    commit     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (KeyRead) begin
          state_nxt  = ST_PRESS_DB;
          latch_code = 1'b1;
        end
      end
      ST_PRESS_DB: begin
        cnt_clear  = 1'b0;
        cnt_enable = 1'b1;
        if (!KeyRead) begin
          state_nxt = ST_IDLE;
        end else if (raw_code != key_code) begin
          latch_code = 1'b1;
          cnt_clear  = 1'b1;
        end else if (cnt_done) begin
          state_nxt = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        // Function keys wait here while an earlier code is still unaccepted.
        if (!is_func || !FuncValid || FuncReady) begin
          commit    = 1'b1;
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!KeyRead) begin
          state_nxt = ST_RELEASE_DB;
        end
      end
      ST_RELEASE_DB: begin
        cnt_clear  = 1'b0;
        cnt_enable = 1'b1;
        if (KeyRead) begin
          state_nxt = ST_HOLD;
        end else if (cnt_done) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      key_code <= '0;
    end else if (latch_code) begin
      key_code <= raw_code;
    end
  end

  assign commit_digit = commit && is_digit(key_code);
  assign commit_func  = commit && is_func;
  assign commit_bksp  = commit && is_bksp;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      Operand       <= '0;
      DigitCount    <= '0;
      EntryOverflow <= 1'b0;
      KeyEvent      <= 1'b0;
    end else begin
      KeyEvent <= commit;
      if (ClearEntry) begin
        Operand       <= '0;
        DigitCount    <= '0;
        EntryOverflow <= 1'b0;
      end else if (commit_digit) begin
        // A zero with nothing entered yet is a leading zero and changes nothing.
        if ((DigitCount != '0) || (key_code != 4'd0)) begin
          if (DigitCount < MAX_DIGITS) begin
            Operand    <= {Operand[4*NDIGITS-5:0], key_code};
            DigitCount <= DigitCount + 1'b1;
          end else begin
            EntryOverflow <= 1'b1;
          end
        end
      end else if (commit_bksp) begin
        EntryOverflow <= 1'b0;
        if (DigitCount != '0) begin
          Operand    <= Operand >> 4;
          DigitCount <= DigitCount - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      FuncValid <= 1'b0;
      FuncCode  <= '0;
    end else if (commit_func) begin
      FuncValid <= 1'b1;
      FuncCode  <= key_code;
    end else if (FuncReady) begin
      FuncValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_key_entry_accumulator.sv
// Scoreboard bench for key_entry_accumulator: stimulus pushes expected results,
// a monitor checks them on each KeyEvent and on each FuncValid/FuncReady transfer.
`timescale 1ns/1ps
module tb_key_entry_accumulator;

  localparam int NDIGITS = 8;
  localparam int DEB     = 16;
  localparam int CNT_W   = $clog2(NDIGITS + 1);

  logic                 CLK = 1'b0;
  logic                 RESET_N = 1'b0;
  logic                 KeyRead = 1'b0;
  logic [0:3]           BCDKey = 4'd0;
  logic                 ClearEntry = 1'b0;
  logic                 FuncReady = 1'b1;
  logic [4*NDIGITS-1:0] Operand;
  logic [CNT_W-1:0]     DigitCount;
  logic                 EntryOverflow;
  logic                 FuncValid;
  logic [3:0]           FuncCode;
  logic                 KeyEvent;

  always #5 CLK = ~CLK;

  key_entry_accumulator #(
    .NDIGITS         (NDIGITS),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .KeyRead       (KeyRead),
    .BCDKey        (BCDKey),
    .ClearEntry    (ClearEntry),
    .FuncReady     (FuncReady),
    .Operand       (Operand),
    .DigitCount    (DigitCount),
    .EntryOverflow (EntryOverflow),
    .FuncValid     (FuncValid),
    .FuncCode      (FuncCode),
    .KeyEvent      (KeyEvent)
  );

  typedef struct {
    logic [31:0] op;
    int          cnt;
    bit          ovf;
    bit          chk_func;
    bit          fv;
    logic [3:0]  fc;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] func_q[$];
  int         model_digits[$];
  bit         model_ovf = 1'b0;
  int         n_checks = 0;
  int         n_errors = 0;
  int         kev_count = 0;
  bit         rnd_mode = 1'b0;
  bit         fixed_ready = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] model_operand();
    logic [63:0] v = 64'd0;
    foreach (model_digits[i]) v = v * 16 + 64'(model_digits[i]);
    return v[31:0];
  endfunction

  function automatic bit key_is_func(input logic [3:0] code);
`ifdef KEYENTRY_BACKSPACE_EN
    return (code >= 4'd10) && (code != 4'hF);
`else
    return code >= 4'd10;
`endif
  endfunction

  task automatic model_clear();
    model_digits.delete();
    model_ovf = 1'b0;
  endtask

  // Apply one committed key to the reference model and queue the expected response.
  task automatic expect_key(input logic [3:0] code, input bit chk_bksp_idle);
    exp_t e;
    int   d = int'(code);
    e.chk_func = 1'b0;
    e.fv = 1'b0;
    e.fc = 4'd0;
    if (d <= 9) begin
      if (!(model_digits.size() == 0 && d == 0)) begin
        if (model_digits.size() < NDIGITS) model_digits.push_back(d);
        else model_ovf = 1'b1;
      end
    end else if (key_is_func(code)) begin
      e.chk_func = 1'b1;
      e.fv = 1'b1;
      e.fc = code;
      func_q.push_back(code);
    end else begin
      if (model_digits.size() > 0) void'(model_digits.pop_back());
      model_ovf = 1'b0;
      e.chk_func = chk_bksp_idle;
    end
    e.op  = model_operand();
    e.cnt = model_digits.size();
    e.ovf = model_ovf;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic press(input logic [3:0] code, input bit switch_code, input bit chk_bksp_idle);
    expect_key(code, chk_bksp_idle);
    KeyRead = 1'b1;
    if (switch_code) begin
      BCDKey = 4'($urandom_range(0, 15));
      tick(3);
    end
    BCDKey = code;
    tick(30);
    KeyRead = 1'b0;
    tick(30);
  endtask

  task automatic press_with_clear(input logic [3:0] code);
    exp_t e;
    model_clear();
    e.op = 32'd0; e.cnt = 0; e.ovf = 1'b0; e.chk_func = 1'b0; e.fv = 1'b0; e.fc = 4'd0;
    exp_q.push_back(e);
    BCDKey  = code;
    KeyRead = 1'b1;
    tick(DEB + 1);
    ClearEntry = 1'b1;
    tick(1);
    ClearEntry = 1'b0;
    tick(12);
    KeyRead = 1'b0;
    tick(30);
  endtask

  task automatic pulse_clear();
    ClearEntry = 1'b1;
    tick(1);
    ClearEntry = 1'b0;
    model_clear();
    tick(1);
  endtask

  task automatic glitch(input int len);
    BCDKey  = 4'($urandom_range(0, 15));
    KeyRead = 1'b1;
    tick(len);
    KeyRead = 1'b0;
    tick(6);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_operand"}, 64'(Operand), 64'(model_operand()));
    check({tag, "_count"}, 64'(DigitCount), 64'(model_digits.size()));
    check({tag, "_overflow"}, 64'(EntryOverflow), 64'(model_ovf));
  endtask

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      FuncReady = rnd_mode ? ($urandom_range(0, 3) != 0) : fixed_ready;
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (KeyEvent === 1'b1) begin
        kev_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_key_event", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("ev_operand", 64'(Operand), 64'(e.op));
          check("ev_count", 64'(DigitCount), 64'(e.cnt));
          check("ev_overflow", 64'(EntryOverflow), 64'(e.ovf));
          if (e.chk_func) begin
            check("ev_func_valid", 64'(FuncValid), 64'(e.fv));
            if (e.fv) check("ev_func_code", 64'(FuncCode), 64'(e.fc));
          end
        end
      end
      if (FuncValid === 1'b1 && FuncReady === 1'b1) begin
        if (func_q.size() == 0) check("unexpected_transfer", 64'd1, 64'd0);
        else check("transfer_code", 64'(FuncCode), 64'(func_q.pop_front()));
      end
    end
  end

  initial begin
    int k0;
    tick(3);
    check("rst_operand", 64'(Operand), 64'd0);
    check("rst_count", 64'(DigitCount), 64'd0);
    check("rst_overflow", 64'(EntryOverflow), 64'd0);
    check("rst_func_valid", 64'(FuncValid), 64'd0);
    check("rst_func_code", 64'(FuncCode), 64'd0);
    check("rst_key_event", 64'(KeyEvent), 64'd0);
    RESET_N = 1'b1;
    tick(2);

    // Reset in the middle of a press; the still-held key must count as a fresh press.
    BCDKey  = 4'd3;
    KeyRead = 1'b1;
    tick(8);
    RESET_N = 1'b0;
    #2;
    RESET_N = 1'b1;
    k0 = kev_count;
    expect_key(4'd3, 1'b0);
    tick(30);
    KeyRead = 1'b0;
    tick(30);
    check("reset_press_events", 64'(kev_count - k0), 64'd1);
    pulse_clear();

    // Single digit press yields exactly one pulse.
    k0 = kev_count;
    press(4'd7, 1'b0, 1'b0);
    check("single_press_events", 64'(kev_count - k0), 64'd1);
    check_idle("digit7");

    // Short glitch commits nothing.
    k0 = kev_count;
    glitch(5);
    check("glitch_events", 64'(kev_count - k0), 64'd0);
    check_idle("after_glitch");

    // Nine digits into eight slots.
    pulse_clear();
    for (int d = 1; d <= 9; d++) press(4'(d), 1'b0, 1'b0);
    check("full_operand", 64'(Operand), 64'h12345678);
    check("full_overflow", 64'(EntryOverflow), 64'd1);

    // Leading zero suppressed; clear beats a simultaneous digit commit.
    pulse_clear();
    press(4'd0, 1'b0, 1'b0);
    press(4'd5, 1'b0, 1'b0);
    check_idle("zero_five");
    press_with_clear(4'd6);
    check_idle("clear_vs_commit");

    // Backpressure: second function key waits until the first is accepted.
    fixed_ready = 1'b0;
    tick(2);
    press(4'd10, 1'b0, 1'b0);
    k0 = kev_count;
    press(4'd11, 1'b0, 1'b0);
    check("stall_events", 64'(kev_count - k0), 64'd0);
    check("stall_func_code", 64'(FuncCode), 64'd10);
    fixed_ready = 1'b1;
    tick(40);
    check("unstall_events", 64'(kev_count - k0), 64'd1);
    check("func_drained", 64'(func_q.size()), 64'd0);

    // Key F: backspace when enabled, otherwise an ordinary function key.
    pulse_clear();
    press(4'd4, 1'b0, 1'b0);
    press(4'd2, 1'b0, 1'b0);
    press(4'hF, 1'b0, 1'b1);
    check_idle("key_f");

    // Randomized mix of digits, function keys, glitches and clears.
    rnd_mode = 1'b1;
    for (int i = 0; i < 60; i++) begin
      int r = $urandom_range(0, 9);
      bit sw = ($urandom_range(0, 3) == 0);
      if (r <= 5)      press(4'($urandom_range(0, 9)), sw, 1'b0);
      else if (r <= 7) press(4'($urandom_range(10, 15)), sw, 1'b0);
      else if (r == 8) glitch($urandom_range(1, 8));
      else             pulse_clear();
    end
    rnd_mode = 1'b0;
    fixed_ready = 1'b1;

    for (int t = 0; t < 200 && (exp_q.size() + func_q.size()) != 0; t++) tick(1);
    check("drain_pending", 64'(exp_q.size() + func_q.size()), 64'd0);
    check_idle("final");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
